// File: rtl/fifo_circ_prog_pkg.sv
// Shared types and helpers for the circular FIFO.
// Optional feature macro: FIFO_ERR_EN (sticky OVF/UDF flags).
package fifo_pkg;

    typedef enum logic [1:0] {
        VACIO = 2'd0,
        OTROS = 2'd1,
        LLENO = 2'd2
    } estado_t;

    // Circular pointer advance: wraps to 0 after the last address.
    function automatic logic [31:0] ptr_inc(input logic [31:0] i_ptr, input logic [31:0] i_last);
        return (i_ptr == i_last) ? 32'd0 : i_ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_circ_prog_if.sv
// Data/flag bundle of the circular FIFO.
// Optional feature macro: FIFO_ERR_EN adds OVF/UDF.
interface fifo_circ_prog_if #(
    parameter int LENGTH = 32,
    parameter int SIZE   = 8
);
    localparam int CW = $clog2(LENGTH + 1);

    logic            WRITE;
    logic            READ;
    logic [SIZE-1:0] DATA_IN;
    logic [SIZE-1:0] DATA_OUT;
    logic [CW-1:0]   USE_DW;
    logic            F_FULL_N;
    logic            F_EMPTY_N;
    logic            F_AFULL_N;
    logic            F_AEMPTY_N;
`ifdef FIFO_ERR_EN
    logic            OVF;
    logic            UDF;

    modport master (output WRITE, READ, DATA_IN,
                    input  DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N, OVF, UDF);
    modport slave  (input  WRITE, READ, DATA_IN,
                    output DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N, OVF, UDF);
`else
    modport master (output WRITE, READ, DATA_IN,
                    input  DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N);
    modport slave  (input  WRITE, READ, DATA_IN,
                    output DATA_OUT, USE_DW, F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N);
`endif

endinterface

// File: rtl/fifo_circ_prog_mem.sv
// LENGTH x SIZE register array: one synchronous write port, one registered
// read port. The read register also carries the empty-FIFO bypass word and
// is the only part of the datapath that is reset.
module fifo_mem #(
    parameter int LENGTH = 32,
    parameter int SIZE   = 8,
    parameter int PW     = 5
) (
    input  logic            tsCLOCK,
    input  logic            tsRESET_N,
    input  logic            i_clear_n,
    input  logic            i_we,
    input  logic [PW-1:0]   i_waddr,
    input  logic [SIZE-1:0] i_wdata,
    input  logic            i_re,
    input  logic [PW-1:0]   i_raddr,
    input  logic            i_byp,
    input  logic [SIZE-1:0] i_byp_data,
    output logic [SIZE-1:0] o_rdata
);

    logic [SIZE-1:0] r_mem [LENGTH];

    // Write port; contents are deliberately left unreset.
    always_ff @(posedge tsCLOCK) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    // Read register: bypass word, stored word, or hold.
    always_ff @(posedge tsCLOCK or negedge tsRESET_N) begin
        if (!tsRESET_N)
            o_rdata <= '0;
        else if (!i_clear_n)
            o_rdata <= '0;
        else if (i_byp)
            o_rdata <= i_byp_data;
        else if (i_re)
            o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/fifo_circ_prog.sv
// Circular-buffer FIFO with programmable almost-full/almost-empty levels.
// Optional feature macro: FIFO_ERR_EN (sticky OVF/UDF error flags).
//
// state | meaning
// VACIO | no words stored
// OTROS | 0 < count < LENGTH
// LLENO | count == LENGTH
module fifo_circ_prog
    import fifo_pkg::*;
#(
    parameter int LENGTH   = 32,
    parameter int SIZE     = 8,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic           tsCLOCK,
    input  logic           tsRESET_N,
    input  logic           CLEAR_N,
    input  logic           scan_in,
    input  logic           scan_enable,
    input  logic           test_mode,
    output logic           scan_out,
    fifo_circ_prog_if.slave bus
);

    localparam int PW = (LENGTH > 2) ? $clog2(LENGTH) : 1;
    localparam int CW = $clog2(LENGTH + 1);
    localparam logic [31:0]   LAST_PTR = 32'(LENGTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LENGTH - 1);

    estado_t       r_state, w_state_nxt;
    logic [PW-1:0] r_wp, r_rp;
    logic [PW-1:0] w_wp_inc, w_rp_inc;
    logic [CW-1:0] r_count;
    logic          w_wr_en, w_rd_en, w_byp;
    logic          w_ovf_set, w_udf_set;
    logic          w_unused_dft;

    assign w_unused_dft = &{1'b0, scan_in, scan_enable, test_mode};
    assign scan_out     = 1'b0;

    assign w_wp_inc = PW'(ptr_inc(32'(r_wp), LAST_PTR));
    assign w_rp_inc = PW'(ptr_inc(32'(r_rp), LAST_PTR));

    // Next state and per-cycle accept decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_byp       = 1'b0;
        w_ovf_set   = 1'b0;
        w_udf_set   = 1'b0;
        case (r_state)
            VACIO: begin
                if (bus.WRITE && bus.READ) begin
                    w_byp = 1'b1;
                end else if (bus.WRITE) begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = OTROS;
                end else if (bus.READ) begin
                    w_udf_set = 1'b1;
                end
            end
            OTROS: begin
                if (bus.WRITE && bus.READ) begin
                    w_wr_en = 1'b1;
                    w_rd_en = 1'b1;
                end else if (bus.WRITE) begin
                    w_wr_en = 1'b1;
                    if (r_count == CNT_LAST)
                        w_state_nxt = LLENO;
                end else if (bus.READ) begin
                    w_rd_en = 1'b1;
                    if (r_count == CW'(1))
                        w_state_nxt = VACIO;
                end
            end
            LLENO: begin
                if (bus.WRITE && bus.READ) begin
                    w_wr_en = 1'b1;
                    w_rd_en = 1'b1;
                end else if (bus.WRITE) begin
                    w_ovf_set = 1'b1;
                end else if (bus.READ) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = OTROS;
                end
            end
            default: w_state_nxt = VACIO;
        endcase
    end

    // State, pointers and count; CLEAR_N behaves like a synchronous reset.
    always_ff @(posedge tsCLOCK or negedge tsRESET_N) begin
        if (!tsRESET_N) begin
            r_state <= VACIO;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (!CLEAR_N) begin
            r_state <= VACIO;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_en)
                r_wp <= w_wp_inc;
            if (w_rd_en)
                r_rp <= w_rp_inc;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FIFO_ERR_EN
    logic r_ovf, r_udf;

    // Sticky error flags, cleared only by reset or CLEAR_N.
    always_ff @(posedge tsCLOCK or negedge tsRESET_N) begin
        if (!tsRESET_N) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (!CLEAR_N) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_set)
                r_ovf <= 1'b1;
            if (w_udf_set)
                r_udf <= 1'b1;
        end
    end

    assign bus.OVF = r_ovf;
    assign bus.UDF = r_udf;
`else
    logic w_unused_err;
    assign w_unused_err = w_ovf_set | w_udf_set;
`endif

    fifo_mem #(
        .LENGTH (LENGTH),
        .SIZE   (SIZE),
        .PW     (PW)
    ) u_mem (
        .tsCLOCK    (tsCLOCK),
        .tsRESET_N  (tsRESET_N),
        .i_clear_n  (CLEAR_N),
        .i_we       (w_wr_en & CLEAR_N),
        .i_waddr    (r_wp),
        .i_wdata    (bus.DATA_IN),
        .i_re       (w_rd_en),
        .i_raddr    (r_rp),
        .i_byp      (w_byp),
        .i_byp_data (bus.DATA_IN),
        .o_rdata    (bus.DATA_OUT)
    );

    assign bus.USE_DW     = r_count;
    assign bus.F_FULL_N   = (r_state != LLENO);
    assign bus.F_EMPTY_N  = (r_state != VACIO);
    assign bus.F_AFULL_N  = !(r_count >= CW'(AF_LEVEL));
    assign bus.F_AEMPTY_N = !(r_count <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_fifo_circ_prog.sv
// Scoreboard bench for fifo_circ_prog: a queue-based model predicts every
// cycle's DATA_OUT, word count and flags; a monitor compares after each edge.
module tb_fifo_circ_prog;

    localparam int LENGTH = 32;
    localparam int SIZE   = 8;
    localparam int AF     = 28;
    localparam int AE     = 4;

    typedef struct {
        logic [7:0] dout;
        int         cnt;
        bit         ovf;
        bit         udf;
    } exp_t;

    logic tsCLOCK     = 1'b0;
    logic tsRESET_N   = 1'b0;
    logic CLEAR_N     = 1'b1;
    logic scan_in     = 1'b0;
    logic scan_enable = 1'b0;
    logic test_mode   = 1'b0;
    logic scan_out;

    int n_cmp = 0;
    int n_err = 0;

    exp_t       sb[$];
    logic [7:0] m_q[$];
    logic [7:0] m_dout = 8'h00;
    bit         m_ovf  = 1'b0;
    bit         m_udf  = 1'b0;

    fifo_circ_prog_if #(.LENGTH(LENGTH), .SIZE(SIZE)) bus ();

    fifo_circ_prog #(
        .LENGTH   (LENGTH),
        .SIZE     (SIZE),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .tsCLOCK     (tsCLOCK),
        .tsRESET_N   (tsRESET_N),
        .CLEAR_N     (CLEAR_N),
        .scan_in     (scan_in),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out    (scan_out),
        .bus         (bus)
    );

    always #5 tsCLOCK = ~tsCLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle that has a prediction is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge tsCLOCK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data_out",   32'(bus.DATA_OUT),   32'(e.dout));
                chk("use_dw",     32'(bus.USE_DW),     32'(e.cnt));
                chk("f_full_n",   32'(bus.F_FULL_N),   32'(e.cnt != LENGTH));
                chk("f_empty_n",  32'(bus.F_EMPTY_N),  32'(e.cnt != 0));
                chk("f_afull_n",  32'(bus.F_AFULL_N),  32'(!(e.cnt >= AF)));
                chk("f_aempty_n", 32'(bus.F_AEMPTY_N), 32'(!(e.cnt <= AE)));
`ifdef FIFO_ERR_EN
                chk("ovf", 32'(bus.OVF), 32'(e.ovf));
                chk("udf", 32'(bus.UDF), 32'(e.udf));
`endif
            end
        end
    end

    // One clock of stimulus plus the model's view of its effect.
    task automatic step(input bit wr, input bit rd, input logic [7:0] din, input bit clr_n = 1'b1);
        exp_t e;
        @(negedge tsCLOCK);
        bus.WRITE   = wr;
        bus.READ    = rd;
        bus.DATA_IN = din;
        CLEAR_N     = clr_n;
        if (!clr_n) begin
            m_q.delete();
            m_dout = 8'h00;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
        end else if (wr && rd) begin
            if (m_q.size() == 0) begin
                m_dout = din;
            end else begin
                m_dout = m_q.pop_front();
                m_q.push_back(din);
            end
        end else if (wr) begin
            if (m_q.size() < LENGTH) m_q.push_back(din);
            else m_ovf = 1'b1;
        end else if (rd) begin
            if (m_q.size() > 0) m_dout = m_q.pop_front();
            else m_udf = 1'b1;
        end
        e.dout = m_dout;
        e.cnt  = m_q.size();
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        sb.push_back(e);
        @(posedge tsCLOCK);
    endtask

    task automatic drain();
        while (m_q.size() > 0) step(1'b0, 1'b1, 8'h00);
    endtask

    task automatic reset_mid();
        @(negedge tsCLOCK);
        bus.WRITE = 1'b0;
        bus.READ  = 1'b0;
        tsRESET_N = 1'b0;
        #1;
        chk("rst_use_dw",    32'(bus.USE_DW),    32'd0);
        chk("rst_data_out",  32'(bus.DATA_OUT),  32'd0);
        chk("rst_f_empty_n", 32'(bus.F_EMPTY_N), 32'd0);
        m_q.delete();
        m_dout = 8'h00;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        @(negedge tsCLOCK);
        tsRESET_N = 1'b1;
    endtask

    initial begin
        int r;
        int p_wr;
        bus.WRITE   = 1'b0;
        bus.READ    = 1'b0;
        bus.DATA_IN = 8'h00;

        // Reset state
        #1;
        chk("init_use_dw",    32'(bus.USE_DW),    32'd0);
        chk("init_data_out",  32'(bus.DATA_OUT),  32'd0);
        chk("init_f_empty_n", 32'(bus.F_EMPTY_N), 32'd0);
        chk("init_f_full_n",  32'(bus.F_FULL_N),  32'd1);
        chk("scan_out",       32'(scan_out),      32'd0);
        @(negedge tsCLOCK);
        tsRESET_N = 1'b1;

        // Ordered fill and drain; count sweep 0..32..0 checked by the monitor
        for (int i = 0; i < LENGTH; i++) step(1'b1, 1'b0, 8'(i));
        #2 chk("full_after_32", 32'(bus.F_FULL_N), 32'd0);
        for (int i = 0; i < LENGTH; i++) step(1'b0, 1'b1, 8'h00);
        #2 chk("empty_after_drain", 32'(bus.F_EMPTY_N), 32'd0);

        // Underflow attempt on empty
        step(1'b0, 1'b1, 8'h00);

        // Wrap pattern: 3 writes, 2 reads, 20 times
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 8'($urandom));
            for (int j = 0; j < 2; j++) step(1'b0, 1'b1, 8'h00);
        end
        #2 chk("wrap_use_dw", 32'(bus.USE_DW), 32'd20);
        drain();

        // Empty bypass
        step(1'b1, 1'b1, 8'hA5);
        #2 chk("bypass_data", 32'(bus.DATA_OUT), 32'hA5);
        chk("bypass_use_dw", 32'(bus.USE_DW), 32'd0);

        // Fill, overflow write, simultaneous read/write while full, drain
        for (int i = 0; i < LENGTH; i++) step(1'b1, 1'b0, 8'($urandom_range(0, 254)));
        step(1'b1, 1'b0, 8'hFF);
        #2 chk("ovf_use_dw", 32'(bus.USE_DW), 32'd32);
`ifdef FIFO_ERR_EN
        chk("ovf_set", 32'(bus.OVF), 32'd1);
`endif
        step(1'b1, 1'b1, 8'h5A);
        drain();

        // Reset with 10 words stored
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'($urandom));
        reset_mid();
        step(1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        #2 chk("post_reset_data", 32'(bus.DATA_OUT), 32'h3C);

        // Synchronous clear while partly full
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b0, 8'h00);

        // Randomised traffic with alternating fill/drain bias
        for (int seg = 0; seg < 8; seg++) begin
            p_wr = (seg % 2 == 0) ? 75 : 25;
            for (int c = 0; c < 250; c++) begin
                r = $urandom_range(0, 99);
                step(r < p_wr, $urandom_range(0, 99) < (100 - p_wr),
                     8'($urandom), $urandom_range(0, 199) != 0);
            end
        end
        step(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge tsCLOCK);
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_circ_prog.md
FIFO_CIRC_PROG -- requirements
Module: fifo_circ_prog

Interface
REQ-001 Parameter LENGTH, default 32: FIFO depth in words, legal range 2..256, any value (not only a power of two).
REQ-002 Parameter SIZE, default 8: data word width in bits.
REQ-003 Parameter AF_LEVEL, default 28: almost-full threshold in words, legal range 1..LENGTH-1.
REQ-004 Parameter AE_LEVEL, default 4: almost-empty threshold in words, legal range 1..LENGTH-1.
REQ-005 tsCLOCK  in  1  clock; all state updates on its rising edge.
REQ-006 tsRESET_N  in  1  reset, asynchronous, active-low.
REQ-007 CLEAR_N  in  1  synchronous clear, active-low.
REQ-008 WRITE  in  1  write request.
REQ-009 READ  in  1  read request.
REQ-010 DATA_IN  in  SIZE  write data.
REQ-011 DATA_OUT  out  SIZE  registered read data.
REQ-012 USE_DW  out  CW=$clog2(LENGTH+1)  current word count, range 0..LENGTH inclusive.
REQ-013 F_FULL_N / F_EMPTY_N  out  1 each  full / empty flags, both active-low.
REQ-014 F_AFULL_N / F_AEMPTY_N  out  1 each  almost-full / almost-empty flags, both active-low.
REQ-015 OVF / UDF  out  1 each  sticky overflow / underflow flags, present only with FIFO_ERR_EN.
REQ-016 scan_in, scan_enable, test_mode  in  1 each; scan_out  out  1: DFT hooks, functionally unused in RTL; scan_out shall be tied to 0.

Function
REQ-017 Storage shall be a circular buffer with write pointer wp and read pointer rp, each wrapping from LENGTH-1 to 0; no data shifting.
REQ-018 State machine of type estado_t: VACIO (count=0), OTROS (0<count<LENGTH), LLENO (count=LENGTH).
REQ-019 Accepted write: mem[wp]<=DATA_IN; wp advances; count+1; allowed in VACIO and OTROS.
REQ-020 Accepted read: DATA_OUT<=mem[rp] on the next edge (1-cycle latency); rp advances; count-1; allowed in OTROS and LLENO.
REQ-021 Transitions: VACIO->OTROS on write-only; OTROS->LLENO on write-only at count=LENGTH-1; OTROS->VACIO on read-only at count=1; LLENO->OTROS on read-only.
REQ-022 READ and WRITE together in VACIO: bypass; DATA_OUT<=DATA_IN; count and pointers unchanged; no UDF.
REQ-023 READ and WRITE together in OTROS or LLENO: read oldest word and write new word in the same cycle; count and state unchanged; no OVF.
REQ-024 WRITE in LLENO without READ: ignored; memory and count unchanged; OVF set.
REQ-025 READ in VACIO without WRITE: ignored; DATA_OUT holds its value; UDF set.
REQ-026 Flags shall be combinational from state and count: F_FULL_N=0 iff LLENO; F_EMPTY_N=0 iff VACIO; F_AFULL_N=0 iff count>=AF_LEVEL; F_AEMPTY_N=0 iff count<=AE_LEVEL.
REQ-027 Pointer and count arithmetic shall be unsigned, explicitly sized to $clog2(LENGTH) and CW bits respectively, with an explicit compare-and-wrap at LENGTH-1.
REQ-028 CLEAR_N=0 at a rising edge shall override READ and WRITE and force the same values as reset.

Reset
REQ-029 tsRESET_N=0 shall immediately set: wp=rp=0, count=0, state VACIO, DATA_OUT=0, OVF=UDF=0.
REQ-030 Memory contents are not reset; reading them before they are written is unreachable by design.
REQ-031 Reset asserted mid-operation shall discard all stored words; the first accepted write after release shall land at address 0.

Configuration
REQ-032 Macro FIFO_ERR_EN defined: OVF and UDF ports and logic exist; each is sticky until reset or CLEAR_N.
REQ-033 Macro FIFO_ERR_EN undefined: OVF and UDF ports are absent; ignored requests remain silently ignored.

Structure
REQ-034 Package fifo_pkg shall hold the estado_t enum (logic [1:0]: VACIO, OTROS, LLENO) and the ptr_inc wrap function.
REQ-035 Sub-module fifo_mem: LENGTH x SIZE register array with one synchronous write port and one synchronous read port, instantiated once.

Verification (LENGTH=32, SIZE=8, AF_LEVEL=28, AE_LEVEL=4)
REQ-036 Write 0x00..0x1F, then read 32 times -> DATA_OUT gives 0x00..0x1F in order, each one cycle after its READ; F_FULL_N=0 after the 32nd write; F_EMPTY_N=0 after the last read.
REQ-037 Write 3 words, read 2, repeat 20 times -> pointers wrap; no data loss; USE_DW ends at 20.
REQ-038 VACIO with READ=WRITE=1 and DATA_IN=0xA5 -> DATA_OUT=0xA5 next cycle; USE_DW stays 0.
REQ-039 Fill to 32, then a 33rd write of 0xFF -> USE_DW=32; OVF=1; draining yields no 0xFF.
REQ-040 Count sweep 0..32 -> F_AEMPTY_N low for counts 0..4; F_AFULL_N low for counts 28..32.
REQ-041 Reset asserted at count=10 -> USE_DW=0, DATA_OUT=0, F_EMPTY_N=0 immediately; next write of 0x3C then read -> DATA_OUT=0x3C.
